rv64_core: RTL and testbench

Single-cycle RV64I integer core, the top-level compute block of the system. It fetches one 32-bit instruction per clock from a combinational instruction memory and accesses a 64-bit-wide byte-masked data memory. Each instruction completes in one cycle. Instruction and data memories are external, Harvard-style.

---
 rtl/rv64_core_if.sv | 12 +
 rtl/rv64_core.sv | 116 +++++++++++
 tb/tb_rv64_core.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rv64_core_if.sv
// rv64_core_if: instruction fetch and data memory bus of the rv64 core
interface rv64_core_if;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] addr;
   logic        wr_en;
   logic [63:0] wdata;
   logic [7:0]  wmask;
   logic [63:0] rdata;
   modport master (input inst, rdata, output pc, addr, wr_en, wdata, wmask);
   modport slave (output inst, rdata, input pc, addr, wr_en, wdata, wmask);
endinterface

// File: rtl/rv64_core.sv
// rv64_core: single-cycle RV64I core; RV64_WORD_OPS_EN adds the *W word ops
module rv64_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic         clk,
   input logic         nrst,
   rv64_core_if.master bus
);
   logic [31:0] pc, npc, inst, addr, imm_s, imm_b, imm_j, wres;
   logic [63:0] rf [32];
   logic [63:0] a, b, opb, imm_i, imm_u, pc64, alu, sra, ld_sh, ld_val, wb;
   logic [6:0]  op, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [7:0]  mask_base;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_opi, is_op;
   logic        is_opiw, is_opw, alt, eq, lt, ltu, taken, wb_en, st_live;
   assign inst = bus.inst;
   assign op = inst[6:0];
   assign rd = inst[11:7];
   assign f3 = inst[14:12];
   assign rs1 = inst[19:15];
   assign rs2 = inst[24:20];
   assign f7 = inst[31:25];
   assign imm_i = {{52{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   assign imm_u = {{32{inst[31]}}, inst[31:12], 12'b0};
   assign pc64 = {32'b0, pc};
   assign is_lui = op == 7'b0110111;
   assign is_auipc = op == 7'b0010111;
   assign is_jal = op == 7'b1101111;
   assign is_jalr = op == 7'b1100111 && f3 == 3'd0;
   assign is_br = op == 7'b1100011 && f3[2:1] != 2'b01;
   assign is_ld = op == 7'b0000011 && f3 != 3'd7;
   assign is_st = op == 7'b0100011 && !f3[2];
   assign is_opi = op == 7'b0010011 && (f3 == 3'd1 ? f7[6:1] == 6'd0 :
                   f3 == 3'd5 ? (f7[6:1] == 6'd0 || f7[6:1] == 6'b010000) : 1'b1);
   assign is_op = op == 7'b0110011 && (f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
`ifdef RV64_WORD_OPS_EN
   logic [31:0] sraw;
   logic        wf7_ok;
   assign wf7_ok = f7 == 7'd0 || (f7 == 7'h20 && f3 == 3'd5);
   assign is_opiw = op == 7'b0011011 && (f3 == 3'd0 || ((f3 == 3'd1 || f3 == 3'd5) && wf7_ok));
   assign is_opw = op == 7'b0111011 && (f3 == 3'd0 ? (f7 == 7'd0 || f7 == 7'h20) :
                   (f3 == 3'd1 || f3 == 3'd5) && wf7_ok);
   assign sraw = $signed(a[31:0]) >>> opb[4:0];
   assign wres = f3 == 3'd0 ? (alt ? a[31:0] - opb[31:0] : a[31:0] + opb[31:0]) :
                 f3 == 3'd1 ? a[31:0] << opb[4:0] : alt ? sraw : a[31:0] >> opb[4:0];
`else
   assign is_opiw = 1'b0;
   assign is_opw = 1'b0;
   assign wres = '0;
`endif
   assign a = rf[rs1];
   assign b = rf[rs2];
   assign opb = (is_op | is_opw | is_br) ? b : imm_i;
   assign alt = inst[30] & (is_op | is_opw | f3 == 3'd5);
   assign eq = a == opb;
   assign lt = $signed(a) < $signed(opb);
   assign ltu = a < opb;
   assign sra = $signed(a) >>> opb[5:0];
   assign addr = a[31:0] + (is_st ? imm_s : imm_i[31:0]);
   assign taken = f3[2:1] == 2'b00 ? eq ^ f3[0] : f3[2:1] == 2'b10 ? lt ^ f3[0] : ltu ^ f3[0];
   // integer ALU shared by OP and OP-IMM
   always_comb begin
      alu = '0;
      case (f3)
         3'd0: alu = alt ? a - opb : a + opb;
         3'd1: alu = a << opb[5:0];
         3'd2: alu = {63'b0, lt};
         3'd3: alu = {63'b0, ltu};
         3'd4: alu = a ^ opb;
         3'd5: alu = alt ? sra : a >> opb[5:0];
         3'd6: alu = a | opb;
         default: alu = a & opb;
      endcase
   end
   assign ld_sh = bus.rdata >> {addr[2:0], 3'b000};
   // load lane extraction; lanes past the doubleword read as zero
   always_comb begin
      ld_val = ld_sh;
      case (f3)
         3'd0: ld_val = {{56{ld_sh[7]}}, ld_sh[7:0]};
         3'd1: ld_val = {{48{ld_sh[15]}}, ld_sh[15:0]};
         3'd2: ld_val = {{32{ld_sh[31]}}, ld_sh[31:0]};
         3'd4: ld_val = {56'b0, ld_sh[7:0]};
         3'd5: ld_val = {48'b0, ld_sh[15:0]};
         3'd6: ld_val = {32'b0, ld_sh[31:0]};
         default: ld_val = ld_sh;
      endcase
   end
   assign wb_en = is_lui | is_auipc | is_jal | is_jalr | is_ld | is_opi | is_op | is_opiw | is_opw;
   assign wb = is_lui ? imm_u : is_auipc ? pc64 + imm_u : (is_jal | is_jalr) ? pc64 + 64'd4 :
               is_ld ? ld_val : (is_opiw | is_opw) ? {{32{wres[31]}}, wres} : alu;
   assign npc = is_jal ? pc + imm_j : is_jalr ? {addr[31:1], 1'b0} :
                (is_br & taken) ? pc + imm_b : pc + 32'd4;
   assign mask_base = f3[1:0] == 2'd0 ? 8'h01 : f3[1:0] == 2'd1 ? 8'h03 : f3[1:0] == 2'd2 ? 8'h0F : 8'hFF;
   assign st_live = is_st & nrst;
   assign bus.pc = pc;
   assign bus.addr = addr;
   assign bus.wr_en = st_live;
   assign bus.wmask = st_live ? mask_base << addr[2:0] : 8'h00;
   assign bus.wdata = st_live ? b << {addr[2:0], 3'b000} : 64'h0;
   // program counter
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) pc <= RESET_PC;
      else pc <= npc;
   end
   // register file; x0 is never written so it stays zero
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) for (int i = 0; i < 32; i++) rf[i] <= '0;
      else if (wb_en && rd != 5'd0) rf[rd] <= wb;
   end
endmodule

// File: tb/tb_rv64_core.sv
// tb_rv64_core: scoreboard bench for rv64_core with a byte-masked data memory model
module tb_rv64_core;
   localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LDO = 7'b0000011;
   localparam logic [6:0] OPIW = 7'b0011011, OPW = 7'b0111011, JALR = 7'b1100111;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0;
   logic nrst = 1'b1;
   int vectors = 0;
   int miscompares = 0;
   logic [63:0] exp_q [$];
   logic [63:0] e;
   logic [63:0] mem [64] = '{33: 64'h1122_3344_5566_7788, default: 64'h0};
   rv64_core_if bus ();
   rv64_core #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .nrst(nrst), .bus(bus));
   always #5 clk = ~clk;
   assign bus.rdata = mem[bus.addr[8:3]];
   always @(posedge clk)
      if (bus.wr_en)
         for (int i = 0; i < 8; i++)
            if (bus.wmask[i]) mem[bus.addr[8:3]][8*i +: 8] <= bus.wdata[8*i +: 8];

   function automatic logic [31:0] ei(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] er(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {f7, rs2, rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] es(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] eb(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] ej(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic issue(input logic [31:0] i);
      @(negedge clk);
      bus.inst = i;
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      nrst = 1'b0;
      bus.inst = NOP;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk);
      nrst = 1'b0;
      bus.inst = es(12'h0, 5'd0, 5'd0, 3'd3);
      #1;
      exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL reset_pc: got %h want %h", bus.pc, e[31:0]); end
      e = exp_q.pop_front(); vectors++; if (bus.wr_en !== e[0]) begin miscompares++; $display("FAIL reset_wr_en: got %b want %b", bus.wr_en, e[0]); end
      e = exp_q.pop_front(); vectors++; if (bus.wmask !== e[7:0]) begin miscompares++; $display("FAIL reset_wmask: got %h want %h", bus.wmask, e[7:0]); end
      repeat (2) @(negedge clk);
      #1;
      exp_q.push_back(64'h0);
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL reset_hold_pc: got %h want %h", bus.pc, e[31:0]); end
      @(negedge clk);
      nrst = 1'b1;
      bus.inst = NOP;
      #1;
      exp_q.push_back(64'h0); exp_q.push_back(64'h4); exp_q.push_back(64'h8);
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL release_pc0: got %h want %h", bus.pc, e[31:0]); end
      issue(NOP);
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL release_pc1: got %h want %h", bus.pc, e[31:0]); end
      issue(NOP);
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL release_pc2: got %h want %h", bus.pc, e[31:0]); end
      exp_q.push_back(64'h1); exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
      issue(es(12'h0, 5'd0, 5'd0, 3'd3));
      e = exp_q.pop_front(); vectors++; if (bus.wr_en !== e[0]) begin miscompares++; $display("FAIL pre_abort_wr_en: got %b want %b", bus.wr_en, e[0]); end
      #2 nrst = 1'b0;
      #1;
      e = exp_q.pop_front(); vectors++; if (bus.wr_en !== e[0]) begin miscompares++; $display("FAIL abort_wr_en: got %b want %b", bus.wr_en, e[0]); end
      e = exp_q.pop_front(); vectors++; if (bus.wmask !== e[7:0]) begin miscompares++; $display("FAIL abort_wmask: got %h want %h", bus.wmask, e[7:0]); end
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL abort_pc: got %h want %h", bus.pc, e[31:0]); end
      @(negedge clk);
      nrst = 1'b1;
      bus.inst = NOP;
   endtask

   task automatic test_alu;
      logic [31:0] prog [11];
      logic [63:0] want [11];
      prog = '{ei(12'hFFF, 5'd0, 3'd0, 5'd1, OPI), ei(12'd60, 5'd1, 3'd5, 5'd2, OPI),
               er(7'h00, 5'd1, 5'd1, 3'd0, 5'd0, OPR), er(7'h20, 5'd1, 5'd0, 3'd0, 5'd3, OPR),
               ei(12'h404, 5'd1, 3'd5, 5'd4, OPI), er(7'h00, 5'd0, 5'd1, 3'd2, 5'd5, OPR),
               er(7'h00, 5'd1, 5'd0, 3'd3, 5'd6, OPR), ei(12'hFFF, 5'd2, 3'd4, 5'd7, OPI),
               {20'h80000, 5'd8, 7'b0110111}, ei(12'h0FF, 5'd7, 3'd7, 5'd9, OPI),
               ei(12'd63, 5'd2, 3'd1, 5'd10, OPI)};
      want = '{64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hF, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1,
               64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_8000_0000, 64'hF0, 64'h8000_0000_0000_0000};
      for (int k = 0; k < 11; k++) issue(prog[k]);
      for (int r = 0; r < 11; r++) begin
         exp_q.push_back(want[r]);
         issue(es(12'h0, 5'(r), 5'd0, 3'd3));
         e = exp_q.pop_front(); vectors++;
         if (bus.wdata !== e) begin miscompares++; $display("FAIL alu_x%0d: got %h want %h", r, bus.wdata, e); end
      end
   endtask

   typedef struct packed {logic [31:0] i; logic st; logic [31:0] a; logic [7:0] m; logic [63:0] d;} ls_t;

   task automatic test_store_load;
      ls_t steps [16];
      logic [63:0] want [9];
      steps = '{'{ei(12'h100, 5'd0, 3'd0, 5'd1, OPI), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h008, 5'd1, 3'd3, 5'd2, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{es(12'h003, 5'd2, 5'd1, 3'd0), 1'b1, 32'h103, 8'h08, 64'h4455_6677_8800_0000},
                '{ei(12'h003, 5'd1, 3'd0, 5'd3, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h003, 5'd1, 3'd4, 5'd4, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h002, 5'd1, 3'd1, 5'd5, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h002, 5'd1, 3'd5, 5'd6, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{es(12'h006, 5'd2, 5'd1, 3'd1), 1'b1, 32'h106, 8'hC0, 64'h7788_0000_0000_0000},
                '{ei(12'h004, 5'd1, 3'd2, 5'd7, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h000, 5'd1, 3'd6, 5'd8, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h000, 5'd1, 3'd2, 5'd9, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{ei(12'h004, 5'd1, 3'd3, 5'd10, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{es(12'h010, 5'd2, 5'd1, 3'd3), 1'b1, 32'h110, 8'hFF, 64'h1122_3344_5566_7788},
                '{ei(12'h010, 5'd1, 3'd3, 5'd11, LDO), 1'b0, 32'h0, 8'h0, 64'h0},
                '{es(12'h004, 5'd2, 5'd1, 3'd2), 1'b1, 32'h104, 8'hF0, 64'h5566_7788_0000_0000},
                '{es(12'h006, 5'd2, 5'd1, 3'd2), 1'b1, 32'h106, 8'hC0, 64'h7788_0000_0000_0000}};
      want = '{64'hFFFF_FFFF_FFFF_FF88, 64'h88, 64'hFFFF_FFFF_FFFF_8800, 64'h8800, 64'h7788_0000,
               64'h8800_0000, 64'hFFFF_FFFF_8800_0000, 64'h0000_0000_7788_0000, 64'h1122_3344_5566_7788};
      for (int k = 0; k < 16; k++) begin
         exp_q.push_back({63'b0, steps[k].st});
         exp_q.push_back({56'b0, steps[k].m});
         exp_q.push_back(steps[k].d);
         if (steps[k].st) exp_q.push_back({32'b0, steps[k].a});
         issue(steps[k].i);
         e = exp_q.pop_front(); vectors++;
         if (bus.wr_en !== e[0]) begin miscompares++; $display("FAIL ls%0d_wr_en: got %b want %b", k, bus.wr_en, e[0]); end
         e = exp_q.pop_front(); vectors++;
         if (bus.wmask !== e[7:0]) begin miscompares++; $display("FAIL ls%0d_wmask: got %h want %h", k, bus.wmask, e[7:0]); end
         e = exp_q.pop_front(); vectors++;
         if (bus.wdata !== e) begin miscompares++; $display("FAIL ls%0d_wdata: got %h want %h", k, bus.wdata, e); end
         if (steps[k].st) begin
            e = exp_q.pop_front(); vectors++;
            if (bus.addr !== e[31:0]) begin miscompares++; $display("FAIL ls%0d_addr: got %h want %h", k, bus.addr, e[31:0]); end
         end
      end
      for (int r = 0; r < 9; r++) begin
         exp_q.push_back(want[r]);
         issue(es(12'h0, 5'(r + 3), 5'd0, 3'd3));
         e = exp_q.pop_front(); vectors++;
         if (bus.wdata !== e) begin miscompares++; $display("FAIL load_x%0d: got %h want %h", r + 3, bus.wdata, e); end
      end
   endtask

   task automatic test_branch;
      logic [31:0] prog [14];
      logic [31:0] pcs [14];
      prog = '{NOP, NOP, ei(12'hFFF, 5'd0, 3'd0, 5'd2, OPI), eb(13'd8, 5'd0, 5'd0, 3'd0),
               eb(13'd8, 5'd0, 5'd0, 3'd1), eb(13'd8, 5'd0, 5'd2, 3'd6), ej(21'h1FFFF0, 5'd1),
               ei(12'h005, 5'd1, 3'd0, 5'd0, JALR), eb(13'd8, 5'd0, 5'd2, 3'd4), eb(13'd12, 5'd0, 5'd2, 3'd7),
               {20'h00001, 5'd3, 7'b0010111}, ei(12'h000, 5'd1, 3'd0, 5'd1, JALR),
               es(12'h0, 5'd1, 5'd0, 3'd3), es(12'h0, 5'd3, 5'd0, 3'd3)};
      pcs = '{32'h04, 32'h08, 32'h0C, 32'h10, 32'h18, 32'h1C, 32'h20, 32'h10, 32'h28, 32'h30,
              32'h3C, 32'h40, 32'h24, 32'h28};
      do_reset;
      for (int k = 0; k < 14; k++) begin
         exp_q.push_back({32'b0, pcs[k]});
         if (k == 12) exp_q.push_back(64'h44);
         if (k == 13) exp_q.push_back(64'h103C);
         issue(prog[k]);
         e = exp_q.pop_front(); vectors++;
         if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL br%0d_pc: got %h want %h", k, bus.pc, e[31:0]); end
         if (k >= 12) begin
            e = exp_q.pop_front(); vectors++;
            if (bus.wdata !== e) begin miscompares++; $display("FAIL br%0d_link: got %h want %h", k, bus.wdata, e); end
         end
      end
   endtask

   task automatic test_word_ops;
      logic [31:0] prog [8];
      logic [63:0] want [3];
      prog = '{ei(12'hFFF, 5'd0, 3'd0, 5'd1, OPI), ei(12'd33, 5'd1, 3'd5, 5'd1, OPI),
               ei(12'h007, 5'd0, 3'd0, 5'd2, OPI), ei(12'h007, 5'd0, 3'd0, 5'd3, OPI),
               ei(12'h007, 5'd0, 3'd0, 5'd4, OPI), ei(12'h001, 5'd1, 3'd0, 5'd2, OPIW),
               er(7'h20, 5'd1, 5'd0, 3'd0, 5'd3, OPW), er(7'h00, 5'd1, 5'd1, 3'd1, 5'd4, OPW)};
`ifdef RV64_WORD_OPS_EN
      want = '{64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0000};
`else
      want = '{64'h7, 64'h7, 64'h7};
`endif
      for (int k = 0; k < 8; k++) issue(prog[k]);
      for (int r = 0; r < 3; r++) begin
         exp_q.push_back(want[r]);
         issue(es(12'h0, 5'(r + 2), 5'd0, 3'd3));
         e = exp_q.pop_front(); vectors++;
         if (bus.wdata !== e) begin miscompares++; $display("FAIL word_x%0d: got %h want %h", r + 2, bus.wdata, e); end
      end
   endtask

   task automatic test_unknown;
      do_reset;
      issue(ei(12'h005, 5'd0, 3'd0, 5'd31, OPI));
      exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
      issue(32'hFFFF_FFFF);
      e = exp_q.pop_front(); vectors++; if (bus.wr_en !== e[0]) begin miscompares++; $display("FAIL unk_wr_en: got %b want %b", bus.wr_en, e[0]); end
      e = exp_q.pop_front(); vectors++; if (bus.wmask !== e[7:0]) begin miscompares++; $display("FAIL unk_wmask: got %h want %h", bus.wmask, e[7:0]); end
      e = exp_q.pop_front(); vectors++; if (bus.wdata !== e) begin miscompares++; $display("FAIL unk_wdata: got %h want %h", bus.wdata, e); end
      exp_q.push_back(64'h0C);
      issue(32'h0000_0073);
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL unk_pc: got %h want %h", bus.pc, e[31:0]); end
      exp_q.push_back(64'h10); exp_q.push_back(64'h5);
      issue(es(12'h0, 5'd31, 5'd0, 3'd3));
      e = exp_q.pop_front(); vectors++; if (bus.pc !== e[31:0]) begin miscompares++; $display("FAIL ecall_pc: got %h want %h", bus.pc, e[31:0]); end
      e = exp_q.pop_front(); vectors++; if (bus.wdata !== e) begin miscompares++; $display("FAIL unk_x31: got %h want %h", bus.wdata, e); end
   endtask

   initial begin
      bus.inst = NOP;
      test_reset;
      test_alu;
      test_store_load;
      test_branch;
      test_word_ops;
      test_unknown;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
